// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder for the MEM stage.
// Accepts one load/store at a time over a valid/ready request channel,
// performs the access after a fixed latency and returns read data (load)
// or an acknowledge with zero data (store) over a valid/ready response channel.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_we_i                  1 = store, 0 = load
//   req_addr_i, req_wdata_i   word address, store data
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_we_o                  response is a store ack
//   rsp_rdata_o               load data, 0 for store acks
//   busy_o                    transaction in flight (stall source)
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 3    // 1..15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_we_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  req_t              req_q;
  req_t              acc;
  logic              go_resp;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request driving the access on the edge that enters RESP. With LATENCY=1
  // that edge is the acceptance edge itself, so the live inputs are used.
  always_comb begin
    acc     = req_q;
    go_resp = 1'b0;
    if (state == IDLE) begin
      acc     = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
      go_resp = req_valid_i && req_ready_o && (LATENCY == 1);
    end else if (state == WAIT) begin
      go_resp = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_q       <= '0;
      cnt         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_we_o    <= 1'b0;
      rsp_rdata_o <= '0;
      busy_o      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i && req_ready_o) begin
          req_q       <= acc;
          cnt         <= CNT_INIT;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          state       <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          // rsp_rdata_o intentionally keeps its last value
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (go_resp) begin
        rsp_valid_o <= 1'b1;
        rsp_we_o    <= acc.we;
        if (acc.we) begin
          mem[acc.addr] <= acc.wdata;
          rsp_rdata_o   <= '0;
        end else begin
          rsp_rdata_o   <= mem[acc.addr];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_we, busy;
  logic [63:0] rsp_rdata;

  logic        l_req_valid, l_req_we, l_rsp_ready;
  logic [7:0]  l_req_addr;
  logic [63:0] l_req_wdata;
  logic        l_req_ready, l_rsp_valid, l_rsp_we, l_busy;
  logic [63:0] l_rsp_rdata;

  int cmp = 0, err = 0;
  logic [63:0] model [256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(64), .LATENCY(3)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .busy_o(busy));

  dmem_responder #(.ADDR_W(8), .DATA_W(64), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(l_req_valid), .req_ready_o(l_req_ready), .req_we_i(l_req_we),
    .req_addr_i(l_req_addr), .req_wdata_i(l_req_wdata),
    .rsp_valid_o(l_rsp_valid), .rsp_ready_i(l_rsp_ready), .rsp_we_o(l_rsp_we),
    .rsp_rdata_o(l_rsp_rdata), .busy_o(l_busy));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  // One transaction on the LATENCY=3 instance. lat counts edges from the
  // acceptance edge (inclusive) until rsp_valid is observed. hold = cycles
  // the response is back-pressured; 0 means rsp_ready is high on entry.
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [63:0] wd,
                        input int hold, output int lat, output logic [63:0] rd,
                        output logic rwe, output logic stable, output logic idle_after);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    rsp_ready = (hold == 0);
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    rd = rsp_rdata; rwe = rsp_we; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== rd || rsp_we !== rwe || req_ready || !busy)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    idle_after = !rsp_valid && req_ready && !busy;
  endtask

  task automatic test_reset();
    int lat; logic [63:0] rd; logic rwe, st, ia;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    clear_model();
    cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== 64'h0) begin
      err++; $display("FAIL reset_outputs: ready=%b valid=%b busy=%b rdata=%h, want 1 0 0 0",
                      req_ready, rsp_valid, busy, rsp_rdata);
    end
    do_txn(1'b0, 8'($urandom_range(0, 255)), '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'h0 || rwe !== 1'b0) begin
      err++; $display("FAIL reset_load: rdata=%h we=%b, want 0 0", rd, rwe);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [63:0] rd; logic rwe, st, ia;
    do_txn(1'b1, 8'd5, 64'hDEAD_BEEF_CAFE_F00D, 0, lat, rd, rwe, st, ia);
    model[5] = 64'hDEAD_BEEF_CAFE_F00D;
    cmp++; if (lat !== 3 || rwe !== 1'b1 || rd !== 64'h0) begin
      err++; $display("FAIL store_ack: lat=%0d we=%b rdata=%h, want 3 1 0", lat, rwe, rd);
    end
    cmp++; if (ia !== 1'b1) begin
      err++; $display("FAIL store_idle: idle_after=%b, want 1", ia);
    end
    do_txn(1'b0, 8'd5, '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (lat !== 3 || rwe !== 1'b0 || rd !== 64'hDEAD_BEEF_CAFE_F00D) begin
      err++; $display("FAIL raw_load: lat=%0d we=%b rdata=%h, want 3 0 deadbeefcafef00d", lat, rwe, rd);
    end
  endtask

  task automatic test_backpressure();
    int n = 0; logic [63:0] rd; logic ok = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; rsp_ready = 1'b0;
    tick();                               // acceptance edge
    req_addr = 8'd0;                      // second request held by initiator
    while (!rsp_valid && n < 40) begin tick(); n++; end
    rd = rsp_rdata;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== rd || req_ready || !busy) ok = 1'b0;
    end
    cmp++; if (ok !== 1'b1 || rd !== model[5]) begin
      err++; $display("FAIL bp_hold: stable=%b rdata=%h, want 1 %h", ok, rd, model[5]);
    end
    rsp_ready = 1'b1;
    tick();                               // response handshake
    rsp_ready = 1'b0;
    cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      err++; $display("FAIL bp_after_hs: valid=%b ready=%b busy=%b, want 0 1 0", rsp_valid, req_ready, busy);
    end
    tick();                               // second request accepted here
    req_valid = 1'b0;
    cmp++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      err++; $display("FAIL bp_second_accept: ready=%b busy=%b, want 0 1", req_ready, busy);
    end
    n = 1;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    cmp++; if (n !== 3 || rsp_rdata !== model[0]) begin
      err++; $display("FAIL bp_second_rsp: lat=%0d rdata=%h, want 3 %h", n, rsp_rdata, model[0]);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    int lat; logic [63:0] rd; logic rwe, st, ia;
    do_txn(1'b1, 8'd0,   64'h1, 0, lat, rd, rwe, st, ia);                  model[0] = 64'h1;
    do_txn(1'b1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF, 0, lat, rd, rwe, st, ia); model[255] = '1;
    do_txn(1'b0, 8'd0, '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'h1) begin err++; $display("FAIL bnd_addr0: rdata=%h, want 1", rd); end
    do_txn(1'b0, 8'd255, '0, 1, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin err++; $display("FAIL bnd_addr255: rdata=%h, want all ones", rd); end
    do_txn(1'b0, 8'd1, '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'h0) begin err++; $display("FAIL bnd_addr1: rdata=%h, want 0", rd); end
    do_txn(1'b0, 8'd254, '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'h0) begin err++; $display("FAIL bnd_addr254: rdata=%h, want 0", rd); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [63:0] rd; logic rwe, st, ia; logic seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd9; req_wdata = 64'h55; rsp_ready = 1'b1;
    tick();                               // accepted, now in WAIT
    req_valid = 1'b0;
    cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      err++; $display("FAIL midop_wait: busy=%b valid=%b, want 1 0", busy, rsp_valid);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    clear_model();
    cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      err++; $display("FAIL midop_idle: ready=%b busy=%b valid=%b, want 1 0 0", req_ready, busy, rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin tick(); if (rsp_valid) seen = 1'b1; end
    cmp++; if (seen !== 1'b0) begin err++; $display("FAIL midop_no_rsp: rsp seen=%b, want 0", seen); end
    rsp_ready = 1'b0;
    do_txn(1'b0, 8'd9, '0, 0, lat, rd, rwe, st, ia);
    cmp++; if (rd !== 64'h0) begin err++; $display("FAIL midop_load: rdata=%h, want 0", rd); end
  endtask

  task automatic test_random();
    int lat; logic [63:0] rd; logic rwe, st, ia;
    logic we; logic [7:0] a; logic [63:0] d; int h;
    int bad = 0;
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));   // small window so loads hit prior stores
      d  = {$urandom, $urandom};
      h  = $urandom_range(0, 3);
      do_txn(we, a, d, h, lat, rd, rwe, st, ia);
      cmp++;
      if (lat !== 3 || rwe !== we || st !== 1'b1 || ia !== 1'b1 ||
          rd !== (we ? 64'h0 : model[a])) begin
        err++; bad++;
        if (bad < 5)
          $display("FAIL rand_txn[%0d]: we=%b addr=%0d lat=%0d rwe=%b rdata=%h stable=%b idle=%b, want lat 3 rdata %h",
                   t, we, a, lat, rwe, rd, st, ia, we ? 64'h0 : model[a]);
      end
      if (we) model[a] = d;
    end
  endtask

  // LATENCY=1: request held valid continuously, rsp_ready high. Expected
  // stream: response visible after every even edge, idle after every odd one.
  task automatic test_lat1();
    logic        ops_we [8];
    logic [7:0]  ops_a  [8];
    logic [63:0] ops_d  [8];
    logic [63:0] m1 [256];
    int k = 0, pulses = 0, bad = 0;
    for (int i = 0; i < 256; i++) m1[i] = '0;
    for (int i = 0; i < 4; i++) begin
      ops_we[i] = 1'b1; ops_a[i] = 8'(i * 7 + 1); ops_d[i] = {$urandom, $urandom};
      ops_we[i+4] = 1'b0; ops_a[i+4] = 8'(i * 7 + 1); ops_d[i+4] = '0;
    end
    l_rsp_ready = 1'b1;
    l_req_valid = 1'b1; l_req_we = ops_we[0]; l_req_addr = ops_a[0]; l_req_wdata = ops_d[0];
    for (int e = 0; e < 16; e++) begin
      tick();
      if (l_rsp_valid !== ((e % 2) == 0)) bad++;
      if (l_rsp_valid) begin
        pulses++;
        if (l_rsp_we !== ops_we[k] || l_rsp_rdata !== (ops_we[k] ? 64'h0 : m1[ops_a[k]])) bad++;
        if (ops_we[k]) m1[ops_a[k]] = ops_d[k];
        k++;
        if (k < 8) begin l_req_we = ops_we[k]; l_req_addr = ops_a[k]; l_req_wdata = ops_d[k]; end
        else l_req_valid = 1'b0;
      end
    end
    cmp++; if (bad !== 0 || pulses !== 8) begin
      err++; $display("FAIL lat1_stream: errors=%0d pulses=%0d, want 0 8", bad, pulses);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    l_req_valid = 1'b0; l_req_we = 1'b0; l_req_addr = '0; l_req_wdata = '0; l_rsp_ready = 1'b0;
    #1;
    test_reset();
    test_store_load();
    test_backpressure();
    test_boundaries();
    test_reset_midop();
    test_random();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
